tracer_packet_serializer: RTL and testbench



---
 rtl/tracer_pkg.sv | 20 ++
 rtl/tracer_pkt_fifo.sv | 66 ++++++
 rtl/tracer_packet_serializer.sv | 174 +++++++++++++++++
 tb/tb_tracer_packet_serializer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tracer_pkg.sv
// rtl/tracer_pkg.sv - shared constants, entry layout and word-count helper for the trace serializer
package tracer_pkg;

    localparam int unsigned TRACE_WORD_WIDTH = 16;
    localparam int unsigned TRACE_PKT_WIDTH  = 64;
    localparam int unsigned TRACE_LEN_WIDTH  = 7;

    // Layout of one buffered packet at the default sizes; the serializer
    // declares the same shape sized from its own parameters.
    typedef struct packed {
        logic [TRACE_PKT_WIDTH-1:0] payload;
        logic [TRACE_LEN_WIDTH-1:0] len;
    } trace_entry_t;

    // Number of output words needed to carry len_bits of payload.
    function automatic int unsigned words_for_len(input int unsigned len_bits);
        return (len_bits + TRACE_WORD_WIDTH - 1) / TRACE_WORD_WIDTH;
    endfunction

endpackage

// File: rtl/tracer_pkt_fifo.sv
// rtl/tracer_pkt_fifo.sv - synchronous packet FIFO with head and head+1 peek
// Ports: i_clk/i_rst_n clock and async active-low reset; i_flush empties the
// buffer; i_push/i_wdata write; i_pop removes the head; o_head/o_next show the
// head and the entry behind it; o_full/o_empty/o_count give occupancy.
// A push while full is accepted when a pop happens on the same edge.
module tracer_pkt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [WIDTH-1:0]         o_next,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    // DEPTH is a power of two, so pointer arithmetic wraps naturally.
    assign o_head = r_mem[r_rd_ptr];
    assign o_next = r_mem[r_rd_ptr + AW'(1)];

endmodule

// File: rtl/tracer_packet_serializer.sv
// rtl/tracer_packet_serializer.sv - buffers trace packets and emits them as 16-bit valid/ready words
// Ports: clk_i/rst_ni clock and async active-low reset; enable_i gates new
// packets; flush_i drops buffer and in-flight word; clr_cnt_i clears the drop
// counter; packet_i/packet_len_i/packet_valid_i are the unstallable packet
// strobe; data_o/valid_o/last_o/ready_i the word stream; busy_o, overflow_o and
// dropped_cnt_o report activity and dropped packets.
module tracer_packet_serializer
    import tracer_pkg::*;
#(
    parameter int PACKET_WIDTH = 64,
    parameter int LEN_WIDTH    = 7,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic                    flush_i,
    input  logic                    clr_cnt_i,
    input  logic [PACKET_WIDTH-1:0] packet_i,
    input  logic [LEN_WIDTH-1:0]    packet_len_i,
    input  logic                    packet_valid_i,
    output logic [15:0]             data_o,
    output logic                    valid_o,
    output logic                    last_o,
    input  logic                    ready_i,
    output logic                    busy_o,
    output logic                    overflow_o,
    output logic [CNT_WIDTH-1:0]    dropped_cnt_o
);

    localparam int NUM_WORDS = PACKET_WIDTH / TRACE_WORD_WIDTH;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int FCNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(PACKET_WIDTH);

    typedef struct packed {
        logic [NUM_WORDS-1:0][TRACE_WORD_WIDTH-1:0] payload;
        logic [LEN_WIDTH-1:0]                       len;
    } entry_t;

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    function automatic logic [IDX_W-1:0] last_idx(input logic [LEN_WIDTH-1:0] len);
        return IDX_W'(words_for_len(32'(len)) - 1);
    endfunction

    state_t                     r_state, w_state_nxt;
    logic [IDX_W-1:0]           r_idx, w_idx_nxt, w_idx_inc;
    logic [15:0]                r_data, w_data_nxt;
    logic                       r_last, w_last_nxt;
    logic                       r_ovf;
    logic [CNT_WIDTH-1:0]       r_cnt;

    logic [LEN_WIDTH-1:0]       w_len_clamped;
    logic [PACKET_WIDTH-1:0]    w_pkt_masked;
    entry_t                     w_in_entry, w_head, w_fifo_next, w_next;
    logic                       w_accept, w_push, w_pop, w_drop, w_next_avail;
    logic                       w_fifo_full, w_fifo_empty;
    logic [FCNT_W-1:0]          w_fifo_count;

    // Payload bits at or above the (clamped) length are zeroed on entry, so
    // the final word needs no masking on the way out.
    always_comb begin
        w_len_clamped = (packet_len_i > LEN_MAX) ? LEN_MAX : packet_len_i;
        for (int i = 0; i < PACKET_WIDTH; i++) begin
            w_pkt_masked[i] = packet_i[i] & (i < int'(w_len_clamped));
        end
        w_in_entry.payload = w_pkt_masked;
        w_in_entry.len     = w_len_clamped;
    end

    // The head stays in the FIFO while its words are on the output, so it
    // still occupies a slot; it is popped as its last word is accepted.
    assign w_accept = packet_valid_i & enable_i & ~flush_i & (packet_len_i != '0);
    assign w_pop    = (r_state == S_FULL) & ready_i & r_last & ~flush_i;
    assign w_push   = w_accept & (~w_fifo_full | w_pop);
    assign w_drop   = w_accept & w_fifo_full & ~w_pop;

    // Packet following the head: buffered behind it, or arriving this cycle
    // when the head is alone, which keeps packet boundaries bubble-free.
    assign w_next_avail = (w_fifo_count >= FCNT_W'(2)) | w_push;
    assign w_next       = (w_fifo_count >= FCNT_W'(2)) ? w_fifo_next : w_in_entry;
    assign w_idx_inc    = r_idx + IDX_W'(1);

    tracer_pkt_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_flush (flush_i),
        .i_push  (w_push),
        .i_wdata (w_in_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_next  (w_fifo_next),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_EMPTY;
            r_idx   <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_last  <= w_last_nxt;
            r_ovf   <= w_drop;
            if (clr_cnt_i) begin
                r_cnt <= w_drop ? CNT_WIDTH'(1) : '0;
            end else if (w_drop && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_last_nxt  = r_last;
        if (flush_i) begin
            w_state_nxt = S_EMPTY;
            w_idx_nxt   = '0;
            w_data_nxt  = '0;
            w_last_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (!w_fifo_empty) begin
                        w_state_nxt = S_FULL;
                        w_idx_nxt   = '0;
                        w_data_nxt  = w_head.payload[0];
                        w_last_nxt  = (last_idx(w_head.len) == '0);
                    end
                end
                S_FULL: begin
                    if (ready_i) begin
                        if (r_last) begin
                            w_idx_nxt = '0;
                            if (w_next_avail) begin
                                w_data_nxt = w_next.payload[0];
                                w_last_nxt = (last_idx(w_next.len) == '0);
                            end else begin
                                w_state_nxt = S_EMPTY;
                                w_last_nxt  = 1'b0;
                            end
                        end else begin
                            w_idx_nxt  = w_idx_inc;
                            w_data_nxt = w_head.payload[w_idx_inc];
                            w_last_nxt = (w_idx_inc == last_idx(w_head.len));
                        end
                    end
                end
            endcase
        end
    end

    assign data_o        = r_data;
    assign valid_o       = (r_state == S_FULL);
    assign last_o        = r_last;
    assign busy_o        = ~w_fifo_empty | (r_state == S_FULL);
    assign overflow_o    = r_ovf;
    assign dropped_cnt_o = r_cnt;

endmodule

// File: tb/tb_tracer_packet_serializer.sv
// tb/tb_tracer_packet_serializer.sv - directed and randomized checks against a queue-based packet model
module tb_tracer_packet_serializer;

    localparam int PW      = 64;
    localparam int LW      = 7;
    localparam int DEPTH   = 4;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          enable, flush, clr_cnt, pkt_valid, ready;
    logic [PW-1:0] pkt;
    logic [LW-1:0] len;
    logic [15:0]   data;
    logic          valid, last, busy, ovf;
    logic [CW-1:0] cnt;

    tracer_packet_serializer #(
        .PACKET_WIDTH (PW),
        .LEN_WIDTH    (LW),
        .FIFO_DEPTH   (DEPTH),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enable_i       (enable),
        .flush_i        (flush),
        .clr_cnt_i      (clr_cnt),
        .packet_i       (pkt),
        .packet_len_i   (len),
        .packet_valid_i (pkt_valid),
        .data_o         (data),
        .valid_o        (valid),
        .last_o         (last),
        .ready_i        (ready),
        .busy_o         (busy),
        .overflow_o     (ovf),
        .dropped_cnt_o  (cnt)
    );

    int errors = 0;
    int checks = 0;
    int n_words, n_last, n_ovf;

    // Reference model: accepted packets in arrival order (head first), plus
    // which word of the head is currently presented.
    logic [PW-1:0] m_pay[$];
    int            m_len[$];
    bit            m_valid;
    int            m_idx;
    bit            m_ovf;
    int            m_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int nwords(input int l);
        return (l + 15) / 16;
    endfunction

    function automatic logic [15:0] exp_word(input logic [PW-1:0] p, input int l, input int k);
        logic [PW-1:0] s;
        logic [15:0]   w;
        int            rem;
        s   = p >> (16 * k);
        w   = s[15:0];
        rem = l - 16 * k;
        if (rem < 16) w = w & 16'((32'd1 << rem) - 32'd1);
        return w;
    endfunction

    task automatic model_reset();
        m_pay.delete();
        m_len.delete();
        m_valid = 1'b0;
        m_idx   = 0;
        m_ovf   = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic model_edge();
        bit acc, pop, drop, had;
        int l;
        l   = (int'(len) > PW) ? PW : int'(len);
        had = (m_pay.size() > 0);
        pop = 1'b0;
        if (m_valid && ready) pop = (m_idx == nwords(m_len[0]) - 1);
        acc  = pkt_valid && enable && !flush && (len != 0);
        drop = acc && (m_pay.size() >= DEPTH) && !pop;
        if (flush) begin
            m_pay.delete();
            m_len.delete();
            m_valid = 1'b0;
            m_idx   = 0;
        end else begin
            if (pop) begin
                void'(m_pay.pop_front());
                void'(m_len.pop_front());
            end
            if (acc && !drop) begin
                m_pay.push_back(pkt);
                m_len.push_back(l);
            end
            if (!m_valid) begin
                if (had) begin
                    m_valid = 1'b1;
                    m_idx   = 0;
                end
            end else if (ready) begin
                if (pop) begin
                    m_idx   = 0;
                    m_valid = (m_pay.size() > 0);
                end else begin
                    m_idx++;
                end
            end
        end
        m_ovf = drop;
        if (clr_cnt) m_cnt = drop ? 1 : 0;
        else if (drop && m_cnt < CNT_MAX) m_cnt++;
    endtask

    task automatic compare();
        check_eq("valid", valid, m_valid);
        if (m_valid) begin
            check_eq("data", data, exp_word(m_pay[0], m_len[0], m_idx));
            check_eq("last", last, (m_idx == nwords(m_len[0]) - 1));
        end
        check_eq("busy", busy, (m_pay.size() > 0) || m_valid);
        check_eq("overflow", ovf, m_ovf);
        check_eq("dropped_cnt", cnt, m_cnt);
        n_ovf += int'(ovf);
    endtask

    task automatic cyc();
        if (valid && ready) begin
            n_words++;
            if (last) n_last++;
        end
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        check_eq("rst_valid", valid, 0);
        check_eq("rst_data", data, 0);
        check_eq("rst_last", last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_overflow", ovf, 0);
        check_eq("rst_cnt", cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic strobe(input logic [PW-1:0] p, input int l);
        pkt       = p;
        len       = LW'(l);
        pkt_valid = 1'b1;
        cyc();
        pkt_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && busy; i++) cyc();
        check_eq("drain_timeout", busy, 0);
    endtask

    logic [PW-1:0] p4;

    initial begin
        enable = 1'b1; flush = 1'b0; clr_cnt = 1'b0; pkt_valid = 1'b0;
        ready = 1'b1; pkt = '0; len = '0;
        n_words = 0; n_last = 0; n_ovf = 0;
        rst_n = 1'b1;
        #1;
        apply_reset();

        // Single 40-bit packet: three words, last on the third, N+2 latency.
        strobe(64'h0000_00AB_CDEF_1234, 40);
        cyc();
        check_eq("t1_valid0", valid, 1);
        check_eq("t1_w0", data, 16'h1234);
        cyc();
        check_eq("t1_w1", data, 16'hCDEF);
        check_eq("t1_last1", last, 0);
        cyc();
        check_eq("t1_w2", data, 16'h00AB);
        check_eq("t1_last2", last, 1);
        cyc();
        check_eq("t1_busy", busy, 0);

        // Five packets into a four-entry buffer while stalled.
        ready = 1'b0;
        n_ovf = 0;
        for (int i = 0; i < 5; i++) strobe({$urandom, $urandom}, 64);
        cyc();
        cyc();
        check_eq("t2_cnt", cnt, 1);
        check_eq("t2_ovf_pulses", n_ovf, 1);
        ready = 1'b1;
        n_words = 0;
        drain();
        check_eq("t2_words", n_words, 16);

        // Back-to-back single-word packets with no bubble.
        strobe(64'h1111, 16);
        strobe(64'h2222, 16);
        check_eq("t3_valid_a", valid, 1);
        check_eq("t3_data_a", data, 16'h1111);
        check_eq("t3_last_a", last, 1);
        cyc();
        check_eq("t3_valid_b", valid, 1);
        check_eq("t3_data_b", data, 16'h2222);
        check_eq("t3_last_b", last, 1);
        cyc();
        check_eq("t3_idle", valid, 0);

        // Stall mid-packet: second word must hold.
        ready = 1'b0;
        p4 = {$urandom, $urandom};
        strobe(p4, 64);
        cyc();
        ready = 1'b1;
        cyc();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_eq("t4_hold_data", data, exp_word(p4, 64, 1));
            check_eq("t4_hold_last", last, 0);
        end
        ready = 1'b1;
        cyc();
        check_eq("t4_next", data, exp_word(p4, 64, 2));
        drain();

        // Flush on the second word with a simultaneous strobe.
        strobe({$urandom, $urandom}, 64);
        cyc();
        cyc();
        flush = 1'b1;
        pkt = {$urandom, $urandom};
        len = 7'd64;
        pkt_valid = 1'b1;
        cyc();
        flush = 1'b0;
        pkt_valid = 1'b0;
        check_eq("t5_valid", valid, 0);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_cnt", cnt, 1);
        n_words = 0;
        for (int i = 0; i < 5; i++) cyc();
        check_eq("t5_no_words", n_words, 0);

        // Zero length, disabled, and over-length strobes.
        strobe({$urandom, $urandom}, 0);
        enable = 1'b0;
        strobe({$urandom, $urandom}, 64);
        enable = 1'b1;
        cyc();
        cyc();
        check_eq("t6_ignored", busy, 0);
        n_words = 0;
        n_last  = 0;
        strobe({$urandom, $urandom}, 100);
        drain();
        check_eq("t6_words", n_words, 4);
        check_eq("t6_lasts", n_last, 1);
        check_eq("t6_cnt", cnt, 1);

        // Reset in the middle of a packet.
        strobe({$urandom, $urandom}, 64);
        cyc();
        cyc();
        apply_reset();
        for (int i = 0; i < 4; i++) cyc();
        check_eq("t7_quiet", valid, 0);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            pkt_valid = ($urandom_range(0, 99) < 40);
            len       = LW'($urandom_range(0, 100));
            pkt       = {$urandom, $urandom};
            enable    = ($urandom_range(0, 19) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            clr_cnt   = ($urandom_range(0, 199) == 0);
            ready     = ($urandom_range(0, 99) < 55);
            cyc();
        end
        pkt_valid = 1'b0;
        flush     = 1'b0;
        clr_cnt   = 1'b0;
        enable    = 1'b1;
        ready     = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
